sr_latch_bank: RTL and testbench
================================

Name: sr_latch_bank

Overview:
- Clocked, parametrised successor to the single-bit NOR SR latch: WIDTH independent SR storage cells behind one clock.
- Each cell has a selectable conflict-resolution mode, per-bit edge pulses, and sticky conflict flags. The s=1/r=1 case is defined and reported rather than "not allowed".
- Used as the state/flag register bank in sequential example designs and as a building block for handshake and status logic.

Parameters:
WIDTH, 8, number of independent SR cells (1..32)
MODE, 0, conflict resolution when s=1 and r=1: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle (JK behaviour)
INIT, 0, reset value of q (WIDTH bits)
CNT_W, 8, width of saturating conflict counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  update enable; 0 = all cells hold
s  input  WIDTH  per-cell set request
r  input  WIDTH  per-cell reset request
clr_flags  input  1  clears conflict and conflict_count
q  output  WIDTH  stored state (registered)
qn  output  WIDTH  always exactly ~q
rise  output  WIDTH  one-cycle pulse, bit went 0->1 at the last edge
fall  output  WIDTH  one-cycle pulse, bit went 1->0 at the last edge
conflict  output  WIDTH  sticky per-cell flag: s=r=1 seen while en=1
conflict_count  output  CNT_W  saturating count of cycles with any conflict

Behaviour:
- Reset:
  - Synchronous, active-low: on a clk edge with rst_n=0, outputs take q=INIT, qn=~INIT, rise=0, fall=0, conflict=0, conflict_count=0.
  - Reset overrides en, s, r and clr_flags.
  - Reset mid-operation discards pending updates. The first edge after reset release evaluates inputs normally.
- Per-cell next state, evaluated at each edge with rst_n=1, en=1:
  - s=0, r=0: hold.
  - s=1, r=0: q=1.
  - s=0, r=1: q=0.
  - s=1, r=1: MODE0 q=0; MODE1 q=1; MODE2 hold; MODE3 q=~q.
- en=0: every q holds, rise=fall=0, no conflict detection. s and r are ignored entirely.
- Latency: q reflects inputs one edge after sampling. No combinational path from s/r to q/qn.
- rise/fall:
  - Registered at the same edge as q: rise[i]=~q_old[i]&q_new[i], fall[i]=q_old[i]&~q_new[i].
  - High for exactly one cycle per transition.
  - MODE3 with sustained s=r=1 gives alternating rise/fall every cycle.
- conflict[i]:
  - Set at the edge where en=1 and s[i]=r[i]=1, in every MODE.
  - Remains set until clr_flags=1 or reset.
- conflict_count:
  - +1 per edge where en=1 and any bit of s&r is 1. Not per bit.
  - Saturates at 2^CNT_W-1 with no wrap.
- clr_flags=1 at an edge:
  - conflict becomes exactly the bits conflicting in that same cycle.
  - conflict_count becomes 1 if any bit conflicts that cycle, else 0. A new event beats the clear.
  - clr_flags does not affect q, rise or fall.
- Cells are fully independent. Mixed set/reset/conflict across bits in one cycle resolve per bit.
- No latches or combinational loops in the implementation. All state sits in clk-edge flops.

Test Plan:
- WIDTH=4, INIT=4'b0000, MODE=0: reset, then s=0001,r=0000 -> q=0001, qn=1110, rise=0001 one cycle; next cycle s=0,r=0 -> q holds 0001, rise=0000.
- MODE=0: q=0001, apply s=0001,r=0001 -> q=0000, fall=0001, conflict=0001, conflict_count=1. Rerun with MODE=1 -> q stays 0001, fall=0000, conflict=0001.
- MODE=3: q=0000, hold s=r=0010 for 4 cycles -> q[1] sequence 1,0,1,0; rise/fall alternate; conflict_count=4; MODE=2 same stimulus -> q[1] stays 0.
- en=0 with s=1111,r=0000 for 3 cycles -> q unchanged, rise=0, no flag change; raise en -> q=1111 next edge.
- CNT_W=2: 5 consecutive conflict cycles -> count 1,2,3,3,3. clr_flags with a same-cycle conflict on bit 2 -> conflict=0100, count=1. clr_flags with no conflict -> 0, 0.
- Set q=1010, conflict=0011, then rst_n=0 for one edge with s=1111 -> q=INIT, conflict=0, count=0, rise=fall=0. Release -> next edge q=1111.

Source files
------------

// File: rtl/sr_latch_bank.sv
// -----------------------------------------------------------------------------
// sr_latch_bank
//
// A bank of WIDTH independent, clocked SR storage cells. It takes the place of
// the classic single-bit NOR SR latch. The s=1/r=1 case is a defined, selectable
// behaviour, and every occurrence is reported through sticky flags and a
// saturating event counter.
//
// Parameters
//   WIDTH  number of independent cells (1..32)
//   MODE   resolution when s=1 and r=1:
//          0 reset wins, 1 set wins, 2 hold, 3 toggle
//   INIT   value loaded into q by reset
//   CNT_W  width of the saturating conflict counter
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset (overrides all other inputs)
//   en             update enable; 0 freezes every cell and ignores s/r
//   s, r           per-cell set / reset requests
//   clr_flags      clears conflict flags and counter (same-cycle events win)
//   q, qn          registered state and its exact complement
//   rise, fall     one-cycle pulses for 0->1 / 1->0 transitions at the last edge
//   conflict       sticky per-cell "s=r=1 seen while enabled" flags
//   conflict_count saturating count of enabled cycles with any conflict
// -----------------------------------------------------------------------------
module sr_latch_bank #(
    parameter int               WIDTH = 8,
    parameter int               MODE  = 0,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_conflict;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_conf_now;
    logic             w_any_conf;

    // Per-cell next state. The conflict case is resolved by the MODE constant,
    // so only one of the branches remains after elaboration.
    always_comb begin
        w_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] && !r[i]) begin
                w_next[i] = 1'b1;
            end else if (!s[i] && r[i]) begin
                w_next[i] = 1'b0;
            end else if (s[i] && r[i]) begin
                case (MODE)
                    0:       w_next[i] = 1'b0;
                    1:       w_next[i] = 1'b1;
                    2:       w_next[i] = r_q[i];
                    default: w_next[i] = ~r_q[i];
                endcase
            end
        end
    end

    // Conflicts only count while the bank is enabled.
    assign w_conf_now = en ? (s & r) : '0;
    assign w_any_conf = |w_conf_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q        <= INIT;
            r_rise     <= '0;
            r_fall     <= '0;
            r_conflict <= '0;
            r_count    <= '0;
        end else begin
            if (en) begin
                r_q    <= w_next;
                r_rise <= ~r_q & w_next;
                r_fall <= r_q & ~w_next;
            end else begin
                r_rise <= '0;
                r_fall <= '0;
            end

            // A conflict in the clearing cycle survives the clear.
            if (clr_flags) begin
                r_conflict <= w_conf_now;
                r_count    <= w_any_conf ? CNT_ONE : '0;
            end else begin
                r_conflict <= r_conflict | w_conf_now;
                if (w_any_conf && (r_count != CNT_MAX)) begin
                    r_count <= r_count + CNT_ONE;
                end
            end
        end
    end

    assign q              = r_q;
    assign qn             = ~r_q;
    assign rise           = r_rise;
    assign fall           = r_fall;
    assign conflict       = r_conflict;
    assign conflict_count = r_count;

endmodule

// File: tb/tb_sr_latch_bank.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_bank
//
// Five 4-bit banks driven by the same inputs: MODE 0..3 with an 8-bit counter
// and INIT=0000, plus a MODE 0 bank with a 2-bit counter and INIT=0110.
// A behavioural model tracks every bank. Directed scenarios are followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_sr_latch_bank;

  localparam int NB = 5;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       clr_flags = 1'b0;

  logic [3:0] dq[NB];
  logic [3:0] dqn[NB];
  logic [3:0] drise[NB];
  logic [3:0] dfall[NB];
  logic [3:0] dconf[NB];
  logic [7:0] dcnt[4];
  logic [1:0] dcnt4;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_latch_bank #(.WIDTH(4), .MODE(g), .INIT(4'b0000), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
      .q(dq[g]), .qn(dqn[g]), .rise(drise[g]), .fall(dfall[g]),
      .conflict(dconf[g]), .conflict_count(dcnt[g])
    );
  end

  sr_latch_bank #(.WIDTH(4), .MODE(0), .INIT(4'b0110), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
    .q(dq[4]), .qn(dqn[4]), .rise(drise[4]), .fall(dfall[4]),
    .conflict(dconf[4]), .conflict_count(dcnt4)
  );

  // ---------------- behavioural model ----------------
  int         m_mode[NB] = '{0, 1, 2, 3, 0};
  int         m_cmax[NB] = '{255, 255, 255, 255, 3};
  logic [3:0] m_init[NB] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
  logic [3:0] m_q[NB];
  logic [3:0] m_rise[NB];
  logic [3:0] m_fall[NB];
  logic [3:0] m_conf[NB];
  int         m_cnt[NB];
  bit         m_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Bit-level rule table: what a cell becomes given its request pair.
  function automatic logic cell_next(logic old, logic sb, logic rb, int mode);
    if (sb && !rb) return 1'b1;
    if (!sb && rb) return 1'b0;
    if (!sb && !rb) return old;
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    if (mode == 2) return old;
    return !old;
  endfunction

  task automatic model_edge(input logic rn, input logic e, input logic [3:0] sv,
                            input logic [3:0] rv, input logic c);
    logic [3:0] nq;
    int         hits;
    for (int k = 0; k < NB; k++) begin
      if (!rn) begin
        m_q[k] = m_init[k];
        m_rise[k] = '0;
        m_fall[k] = '0;
        m_conf[k] = '0;
        m_cnt[k] = 0;
      end else begin
        hits = 0;
        nq = m_q[k];
        for (int b = 0; b < 4; b++) begin
          if (e) nq[b] = cell_next(m_q[k][b], sv[b], rv[b], m_mode[k]);
          m_rise[k][b] = e && !m_q[k][b] && nq[b];
          m_fall[k][b] = e && m_q[k][b] && !nq[b];
          if (e && sv[b] && rv[b]) hits++;
        end
        m_q[k] = nq;
        if (c) begin
          m_conf[k] = e ? (sv & rv) : 4'b0000;
          m_cnt[k] = (hits > 0) ? 1 : 0;
        end else begin
          if (e) m_conf[k] = m_conf[k] | (sv & rv);
          if (hits > 0 && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input int k, input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: got %b expected %b at %0t", name, k, got, exp, $time);
    end
  endtask

  // Hand-computed expectation: pins both the DUT and the model to a literal.
  task automatic lit(input string name, input int k, input logic [7:0] got,
                     input logic [7:0] mval, input logic [7:0] exp);
    check({name, "_dut"}, k, got, exp);
    check({name, "_model"}, k, mval, exp);
  endtask

  function automatic logic [7:0] dut_cnt(int k);
    return (k < 4) ? dcnt[k] : {6'b0, dcnt4};
  endfunction

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < NB; k++) begin
        check("q", k, {4'b0, dq[k]}, {4'b0, m_q[k]});
        check("qn", k, {4'b0, dqn[k]}, {4'b0, ~m_q[k]});
        check("rise", k, {4'b0, drise[k]}, {4'b0, m_rise[k]});
        check("fall", k, {4'b0, dfall[k]}, {4'b0, m_fall[k]});
        check("conflict", k, {4'b0, dconf[k]}, {4'b0, m_conf[k]});
        check("count", k, dut_cnt(k), 8'(m_cnt[k]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic e, input logic [3:0] sv,
                      input logic [3:0] rv, input logic c);
    rst_n = rn;
    en = e;
    s = sv;
    r = rv;
    clr_flags = c;
    @(posedge clk);
    #1;
    model_edge(rn, e, sv, rv, c);
    m_valid = 1'b1;
  endtask

  initial begin
    // Reset
    step(0, 0, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b1111, 4'b0000, 1);
    lit("rst_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_0000);
    lit("rst_q", 4, {4'b0, dq[4]}, {4'b0, m_q[4]}, 8'b0000_0110);
    lit("rst_cnt", 0, dut_cnt(0), 8'(m_cnt[0]), 8'd0);

    // Set, then hold
    step(1, 1, 4'b0001, 4'b0000, 0);
    lit("set_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_0001);
    lit("set_qn", 0, {4'b0, dqn[0]}, {4'b0, ~m_q[0]}, 8'b0000_1110);
    lit("set_rise", 0, {4'b0, drise[0]}, {4'b0, m_rise[0]}, 8'b0000_0001);
    step(1, 1, 4'b0000, 4'b0000, 0);
    lit("hold_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_0001);
    lit("hold_rise", 0, {4'b0, drise[0]}, {4'b0, m_rise[0]}, 8'b0000_0000);

    // Conflict on bit 0: reset-dominant vs set-dominant
    step(1, 1, 4'b0001, 4'b0001, 0);
    lit("m0_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_0000);
    lit("m0_fall", 0, {4'b0, dfall[0]}, {4'b0, m_fall[0]}, 8'b0000_0001);
    lit("m0_conf", 0, {4'b0, dconf[0]}, {4'b0, m_conf[0]}, 8'b0000_0001);
    lit("m0_cnt", 0, dut_cnt(0), 8'(m_cnt[0]), 8'd1);
    lit("m1_q", 1, {4'b0, dq[1]}, {4'b0, m_q[1]}, 8'b0000_0001);
    lit("m1_fall", 1, {4'b0, dfall[1]}, {4'b0, m_fall[1]}, 8'b0000_0000);
    lit("m1_conf", 1, {4'b0, dconf[1]}, {4'b0, m_conf[1]}, 8'b0000_0001);

    // Sustained conflict on bit 1: toggle vs hold (first cycle also clears)
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4'b0010, 4'b0010, (i == 0));
      lit("m3_q", 3, {4'b0, dq[3]}, {4'b0, m_q[3]}, (i % 2 == 0) ? 8'b0000_0010 : 8'b0);
      lit("m3_rise", 3, {4'b0, drise[3]}, {4'b0, m_rise[3]}, (i % 2 == 0) ? 8'b0000_0010 : 8'b0);
      lit("m3_fall", 3, {4'b0, dfall[3]}, {4'b0, m_fall[3]}, (i % 2 == 1) ? 8'b0000_0010 : 8'b0);
      lit("m2_q", 2, {4'b0, dq[2]}, {4'b0, m_q[2]}, 8'b0000_0001);
    end
    lit("m3_cnt", 3, dut_cnt(3), 8'(m_cnt[3]), 8'd4);

    // Enable low: everything frozen
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'b1111, 4'b0000, 0);
      lit("en0_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_0000);
      lit("en0_rise", 0, {4'b0, drise[0]}, {4'b0, m_rise[0]}, 8'b0000_0000);
      lit("en0_conf", 0, {4'b0, dconf[0]}, {4'b0, m_conf[0]}, 8'b0000_0010);
    end
    step(1, 1, 4'b1111, 4'b0000, 0);
    lit("en1_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_1111);
    lit("en1_rise", 0, {4'b0, drise[0]}, {4'b0, m_rise[0]}, 8'b0000_1111);

    // 2-bit counter saturation and clear interaction
    step(1, 1, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 4'b0001, 4'b0001, 0);
      lit("sat_cnt", 4, dut_cnt(4), 8'(m_cnt[4]), (i < 3) ? 8'(i + 1) : 8'd3);
    end
    step(1, 1, 4'b0100, 4'b0100, 1);
    lit("clr_hit_conf", 4, {4'b0, dconf[4]}, {4'b0, m_conf[4]}, 8'b0000_0100);
    lit("clr_hit_cnt", 4, dut_cnt(4), 8'(m_cnt[4]), 8'd1);
    step(1, 1, 4'b0000, 4'b0000, 1);
    lit("clr_conf", 4, {4'b0, dconf[4]}, {4'b0, m_conf[4]}, 8'b0000_0000);
    lit("clr_cnt", 4, dut_cnt(4), 8'(m_cnt[4]), 8'd0);

    // Reset mid-operation
    step(1, 1, 4'b0011, 4'b0011, 0);
    step(1, 1, 4'b1010, 4'b0101, 0);
    lit("pre_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_1010);
    lit("pre_conf", 0, {4'b0, dconf[0]}, {4'b0, m_conf[0]}, 8'b0000_0011);
    step(0, 1, 4'b1111, 4'b0000, 0);
    lit("mid_rst_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_0000);
    lit("mid_rst_q", 4, {4'b0, dq[4]}, {4'b0, m_q[4]}, 8'b0000_0110);
    lit("mid_rst_conf", 0, {4'b0, dconf[0]}, {4'b0, m_conf[0]}, 8'b0000_0000);
    lit("mid_rst_fall", 0, {4'b0, dfall[0]}, {4'b0, m_fall[0]}, 8'b0000_0000);
    lit("mid_rst_cnt", 0, dut_cnt(0), 8'(m_cnt[0]), 8'd0);
    step(1, 1, 4'b1111, 4'b0000, 0);
    lit("release_q", 0, {4'b0, dq[0]}, {4'b0, m_q[0]}, 8'b0000_1111);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 7) != 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
